// File: rtl/cim_pkg.sv
// cim_pkg: shared sizes and loader state encoding for the CIM weight loader.
package cim_pkg;
  localparam int ROWS = 8;
  localparam int WW = 12;
  localparam int DW = 2 * WW;
  localparam int ROW_W = $clog2(ROWS);
  localparam int LEN_W = $clog2(ROWS) + 1;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, SETUP, WRITE, HOLD, DONE} loader_state_t;
endpackage

// File: rtl/cim_weight_loader_if.sv
// cim_weight_loader_if: burst command and weight stream handshakes into the loader.
interface cim_weight_loader_if;
  import cim_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_bank;
  logic [ROW_W-1:0] cmd_row;
  logic [LEN_W-1:0] cmd_len;
  logic s_valid;
  logic s_ready;
  logic [DW-1:0] s_data;
  modport master (output cmd_valid, cmd_bank, cmd_row, cmd_len, s_valid, s_data, input cmd_ready, s_ready);
  modport slave (input cmd_valid, cmd_bank, cmd_row, cmd_len, s_valid, s_data, output cmd_ready, s_ready);
endinterface

// File: rtl/cim_row_dec.sv
// cim_row_dec: registered one-hot row strobe decoder for the two array banks.
module cim_row_dec
  import cim_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bank,
  input  logic [ROW_W-1:0] row,
  output logic [ROWS-1:0]  WA0,
  output logic [ROWS-1:0]  WA1
);
  logic [ROWS-1:0] oh;
  assign oh = ROWS'(1) << row;
  always_ff @(posedge clk) begin
    if (rst) begin
      WA0 <= '0;
      WA1 <= '0;
    end else begin
      WA0 <= (en && !bank) ? oh : '0;
      WA1 <= (en && bank) ? oh : '0;
    end
  end
endmodule

// File: rtl/cim_weight_loader.sv
// cim_weight_loader: turns burst commands and weight words into single-cycle row-write pulses.
module cim_weight_loader
  import cim_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cim_weight_loader_if.slave   bus,
  output logic [DW-1:0]        D,
  output logic [ROWS-1:0]      WA0,
  output logic [ROWS-1:0]      WA1,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  loader_state_t state, next;
  logic bank_q;
  logic [ROW_W-1:0] row_q;
  logic [LEN_W-1:0] rem_q;
  logic cmd_fire, s_fire, bad;
  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign s_fire = bus.s_valid && bus.s_ready;
  assign bad = (bus.cmd_len == '0) || (bus.cmd_len > LEN_W'(ROWS));
  assign bus.cmd_ready = state == IDLE;
  assign bus.s_ready = state == WAIT_DATA;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = (cmd_fire && !bad) ? WAIT_DATA : IDLE;
      WAIT_DATA: next = s_fire ? SETUP : WAIT_DATA;
      SETUP:     next = WRITE;
      WRITE:     next = HOLD;
      HOLD:      next = (rem_q == LEN_W'(1)) ? DONE : WAIT_DATA;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      D <= '0;
      err <= 1'b0;
      bank_q <= 1'b0;
      row_q <= '0;
      rem_q <= '0;
    end else begin
      state <= next;
      err <= cmd_fire && bad;
      if (cmd_fire) begin
        bank_q <= bus.cmd_bank;
        row_q <= bus.cmd_row;
        rem_q <= bus.cmd_len;
      end
      if (s_fire) D <= bus.s_data;
      if (state == HOLD) begin
        rem_q <= rem_q - 1'b1;
        row_q <= (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end
    end
  end
  // Strobe registered one cycle after SETUP so the pulse lands exactly in WRITE.
  cim_row_dec u_dec (
    .clk(clk),
    .rst(rst),
    .en(state == SETUP),
    .bank(bank_q),
    .row(row_q),
    .WA0(WA0),
    .WA1(WA1)
  );
endmodule

// File: tb/tb_cim_weight_loader.sv
// tb_cim_weight_loader: directed bench for the weight loader with a behavioural array model.
module tb_cim_weight_loader;
  import cim_pkg::*;
  logic clk, rst;
  logic [DW-1:0] D;
  logic [ROWS-1:0] WA0, WA1;
  logic busy, done, err;
  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic [DW-1:0] arr0 [ROWS];
  logic [DW-1:0] arr1 [ROWS];
  logic [DW-1:0] dat [ROWS];
  cim_weight_loader_if bus ();
  cim_weight_loader dut (
    .clk(clk), .rst(rst), .bus(bus), .D(D), .WA0(WA0), .WA1(WA1),
    .busy(busy), .done(done), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (|{WA0, WA1}) pulses <= pulses + 1;
    for (int i = 0; i < ROWS; i++) begin
      if (WA0[i]) arr0[i] <= D;
      if (WA1[i]) arr1[i] <= D;
    end
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [95:0] pack_a(input logic b);
    logic [95:0] r;
    for (int i = 0; i < ROWS; i++) r[12*i +: 12] = b ? arr1[i][23:12] : arr0[i][23:12];
    return r;
  endfunction
  function automatic logic [95:0] pack_b(input logic b);
    logic [95:0] r;
    for (int i = 0; i < ROWS; i++) r[12*i +: 12] = b ? arr1[i][11:0] : arr0[i][11:0];
    return r;
  endfunction
  task automatic check_reset_vals();
    chk("rst_D", D, 0);
    chk("rst_WA", {WA0, WA1}, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
  endtask
  // Entered at a WAIT_DATA negedge; returns at the negedge after HOLD.
  task automatic word(input logic b, input int r, input logic [DW-1:0] w);
    logic [ROWS-1:0] oh;
    oh = ROWS'(1) << r;
    chk("wait_s_ready", bus.s_ready, 1);
    bus.s_valid = 1'b1;
    bus.s_data = w;
    @(negedge clk);
    bus.s_data = ~w;
    chk("setup_D", D, w);
    chk("setup_WA", {WA0, WA1}, 0);
    chk("setup_s_ready", bus.s_ready, 0);
    @(negedge clk);
    chk("write_D", D, w);
    chk("write_WA0", WA0, b ? '0 : oh);
    chk("write_WA1", WA1, b ? oh : '0);
    @(negedge clk);
    chk("hold_D", D, w);
    chk("hold_WA", {WA0, WA1}, 0);
    @(negedge clk);
  endtask
  task automatic burst(input logic b, input int r, input int len, input int gap_after);
    int p0;
    p0 = pulses;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_bank = b;
    bus.cmd_row = ROW_W'(r);
    bus.cmd_len = LEN_W'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("busy_after_cmd", busy, 1);
    chk("cmd_ready_busy", bus.cmd_ready, 0);
    for (int i = 0; i < len; i++) begin
      if (i == gap_after) begin
        bus.s_valid = 1'b0;
        for (int g = 0; g < 5; g++) begin
          chk("gap_s_ready", bus.s_ready, 1);
          chk("gap_WA", {WA0, WA1}, 0);
          chk("gap_D", D, dat[i-1]);
          @(negedge clk);
        end
      end
      word(b, (r + i) % ROWS, dat[i]);
    end
    bus.s_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_cmd_ready", bus.cmd_ready, 0);
    chk("pulse_count", pulses - p0, len);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_busy", busy, 0);
  endtask
  task automatic illegal(input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_bank = 1'b0;
    bus.cmd_row = '0;
    bus.cmd_len = LEN_W'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_cmd_ready", bus.cmd_ready, 1);
    chk("ill_WA", {WA0, WA1}, 0);
    @(negedge clk);
    chk("ill_err_clear", err, 0);
    chk("ill_busy2", busy, 0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_bank = 1'b0;
    bus.cmd_row = '0;
    bus.cmd_len = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ROWS; i++) dat[i] = {12'h100 + 12'(i), 12'hA00 + 12'(i)};
    burst(1'b0, 0, 8, -1);
    chk("wb0_a", pack_a(1'b0), 96'h107106105104103102101100);
    chk("wb0_b", pack_b(1'b0), 96'hA07A06A05A04A03A02A01A00);
    dat[0] = 24'h200B00;
    dat[1] = 24'h200B01;
    dat[2] = 24'h200B02;
    burst(1'b1, 6, 3, -1);
    chk("wrap_r6", arr1[6], 24'h200B00);
    chk("wrap_r7", arr1[7], 24'h200B01);
    chk("wrap_r0", arr1[0], 24'h200B02);
    for (int i = 0; i < 4; i++) dat[i] = {12'h500 + 12'(i), 12'hE00 + 12'(i)};
    burst(1'b1, 2, 4, 2);
    chk("bp_r2", arr1[2], 24'h500E00);
    chk("bp_r5", arr1[5], 24'h503E03);
    chk("bp_r0_kept", arr1[0], 24'h200B02);
    illegal(0);
    illegal(9);
    for (int i = 0; i < 4; i++) dat[i] = {12'h300 + 12'(i), 12'hC00 + 12'(i)};
    bus.cmd_valid = 1'b1;
    bus.cmd_bank = 1'b0;
    bus.cmd_row = '0;
    bus.cmd_len = 4'd4;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) word(1'b0, i, dat[i]);
    bus.s_valid = 1'b1;
    bus.s_data = dat[3];
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    chk("rst_write_WA0", WA0, 8'h08);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals();
    @(negedge clk);
    chk("rst_stays_idle", busy, 0);
    dat[0] = 24'h400C00;
    burst(1'b0, 0, 1, -1);
    dat[0] = 24'hDEADBE;
    burst(1'b0, 3, 1, -1);
    chk("ow_r3", arr0[3], 24'hDEADBE);
    chk("ow_r4", arr0[4], 24'h104A04);
    chk("final_wb0_a", pack_a(1'b0), 96'h107106105104DEA302301400);
    chk("final_wb0_b", pack_b(1'b0), 96'hA07A06A05A04DBEC02C01C00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cim_weight_loader.md
# cim_weight_loader

Sequential write controller for `cim_array`; it drives the array's `D`, `WA0` and `WA1` inputs.
- Accepts a burst command (bank, start row, length) and a valid/ready stream of 24-bit weight words.
- Turns them into glitch-free, one-hot, single-cycle row-write pulses with data setup and hold margins around each pulse.
- Sits between the weight-fetch path and the CIM macro and is the only agent that writes the array.

## Interface
- `ROWS`, 8, rows per bank; also the width of each `WA` vector.
- `WW`, 12, half-word width; each row stores an `a` word and a `b` word.
- `DW`, 24, data width, fixed at 2*`WW`; `D` = {a, b}.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_bank`  in  1  0 selects `WA0`, 1 selects `WA1`.
- `cmd_row`  in  3  first row to write.
- `cmd_len`  in  4  words in the burst; legal range 1..`ROWS`.
- `s_valid`  in  1  weight word offered.
- `s_ready`  out  1  high only in WAIT_DATA.
- `s_data`  in  `DW`  weight word {a, b}.
- `D`  out  `DW`  array write data, registered.
- `WA0`  out  `ROWS`  bank-0 row write strobes, registered, one-hot or zero.
- `WA1`  out  `ROWS`  bank-1 row write strobes, registered, one-hot or zero.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- States: IDLE, WAIT_DATA, SETUP, WRITE, HOLD, DONE.
- IDLE, command handshake (`cmd_valid` && `cmd_ready`):
  - Latch bank, row and remaining count.
  - If `cmd_len` is 0 or greater than `ROWS`: next cycle `err`=1, stay in IDLE, no write activity.
  - Otherwise go to WAIT_DATA.
- WAIT_DATA, stream handshake (`s_valid` && `s_ready`):
  - Register `s_data` into `D`, go to SETUP.
  - With `s_valid`=0: remain in WAIT_DATA, `D` holds its last value, `WA` stays zero.
- SETUP → WRITE → HOLD:
  - In WRITE, exactly one bit `WA<bank>[row]` is 1.
  - In SETUP and HOLD, all `WA` bits are 0.
  - `D` is constant from SETUP through HOLD.
- HOLD exit:
  - Decrement the remaining count.
  - Advance the row with wrap-around modulo `ROWS`; the bank never changes within a burst.
  - Go to WAIT_DATA if the remaining count is nonzero, otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Invariant: `popcount(WA0|WA1)` ≤ 1 in every cycle; `WA0` and `WA1` are never both nonzero.
- Commands offered while `busy`=1 are ignored because `cmd_ready`=0.
- Stream words offered outside WAIT_DATA are not transferred.

## Timing
- Reset values: `D`=0, `WA0`=0, `WA1`=0, `s_ready`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1; state is IDLE.
- Reset mid-burst:
  - Next edge forces the reset values.
  - Rows already written keep their data; a row interrupted in WRITE is undefined in the array.
  - The burst is not resumed.
- Per-word sequence, with the data handshake at edge N:
  - N+1: SETUP.
  - N+2: WRITE pulse.
  - N+3: HOLD.
  - N+4: WAIT_DATA, `s_ready`=1.
- Throughput: one word per 4 cycles when `s_valid` is held high.
- Command handshake at edge C: `s_ready` first high at C+1.
- Last HOLD at cycle H: `done` at H+1, `cmd_ready` at H+2.
- Rejected command handshake at edge C: `err` at C+1, `cmd_ready` stays 1.

## Structure
- Package `cim_pkg` holds:
  - `ROWS`, `WW`, `DW`.
  - `ROW_W` = $clog2(`ROWS`).
  - `LEN_W` = $clog2(`ROWS`)+1.
  - State enum `loader_state_t`.
- Sub-module `cim_row_dec`: registered-output decoder with inputs en, bank, row and outputs `WA0`/`WA1`, one-hot or zero. It is instantiated once.

## Test plan
Each scenario also checks the resulting `cim_array` contents (row i at bits [12i+11:12i]).
- Full bank-0 load, `s_valid` always high:
  - Stimulus: cmd(bank0, row0, len8), data `{12'h100+i, 12'hA00+i}`.
  - `WA0` pulses 01,02,...,80 every 4 cycles; `WA1`=0.
  - `D` matches at each pulse; `done` one cycle after the last HOLD.
  - `wb0_a`=96'h107106105104103102101100.
- Bank-1 wrap:
  - Stimulus: cmd(bank1, row6, len3), data 24'h200B00, 24'h200B01, 24'h200B02.
  - `WA1` pulses 40, 80, 01; `WA0` stays 0.
- Backpressure:
  - Stimulus: `s_valid` dropped for 5 cycles after word 2.
  - `s_ready`=1 throughout the gap, `WA`=0, `D` unchanged, no extra pulses.
  - The burst completes with exactly `cmd_len` pulses.
- Illegal commands (`cmd_len`=0, then `cmd_len`=9):
  - `err` pulses once per command; no `WA` activity, `busy` stays 0.
- Reset during the WRITE of row 3:
  - Next cycle all outputs return to their reset values.
  - A following cmd(bank0, row0, len1) writes normally.
- Overwrite:
  - Stimulus: cmd(bank0, row3, len1), data 24'hDEADBE.
  - Single `WA0`=08 pulse; row 3 holds a=12'hDEA, b=12'hDBE; other rows unchanged.
